// File: rtl/matmul_feeder_pkg.sv
// Shared definitions for the matmul_feeder slice.
//   ROW_W/LANE_W/LANES : geometry of one array row (5 x int8 lanes)
//   row_t              : one 40b row
//   state_t            : one-hot feeder FSM states
//   row_is_zero()      : detects the array's phase terminator value
package matmul_feeder_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 5;
  localparam int ROW_W  = LANE_W * LANES;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [7:0] {
    S_IDLE  = 8'b0000_0001,
    S_FILL  = 8'b0000_0010,
    S_WLEAD = 8'b0000_0100,
    S_WSEND = 8'b0000_1000,
    S_WTERM = 8'b0001_0000,
    S_ISEND = 8'b0010_0000,
    S_ITERM = 8'b0100_0000,
    S_WAIT  = 8'b1000_0000
  } state_t;

  // The array treats an all-zero row as end-of-phase, so such a row can
  // never be carried as payload.
  function automatic logic row_is_zero(input row_t r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/matmul_feeder_if.sv
// Host row stream into the feeder (valid/ready).
//   s_valid : host row valid        (master -> slave)
//   s_data  : 40b row, lane [39:32] first (master -> slave)
//   s_ready : feeder accepts row    (slave -> master)
interface matmul_feeder_if;
  import matmul_feeder_pkg::*;

  logic s_valid;
  logic s_ready;
  row_t s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/matmul_feeder_buf.sv
// Job buffer: DEPTH x 40b register file, one synchronous write port and one
// asynchronous read port.
//   CLK     : clock
//   wr_en   : write strobe
//   wr_addr : write row index
//   wr_data : row to store
//   rd_addr : read row index
//   rd_data : row at rd_addr (combinational)
module matmul_feeder_buf
  import matmul_feeder_pkg::*;
#(
  parameter int DEPTH = 15,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  row_t          wr_data,
  input  logic [AW-1:0] rd_addr,
  output row_t          rd_data
);

  row_t mem [DEPTH];

  // NOTE: storage has no reset; every entry is written during FILL before it
  // is ever read, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/matmul_feeder.sv
// Upstream sequencer for the 5x5 systolic MAC array. Buffers one job
// (N weight rows then T input rows) from the host stream and replays it on
// the array's zero-terminated Weight/In ports, then counts result beats.
//   CLK, RSTN : clock, asynchronous active-low reset
//   s         : host row stream (slave modport)
//   weight_o  : to array Weight_i      in_o : to array In_i
//   val_i     : array VAL_o            ov_i : array OV_o
//   busy      : job in progress        done : 1-cycle pulse, T beats counted
//   ov_seen   : sticky overflow seen while waiting for results
//   err       : 1-cycle pulse, zero row rejected or watchdog expired
// Optional feature: define MATMUL_FEEDER_TIMEOUT_EN to add a WAIT watchdog of
// TMO cycles.
module matmul_feeder
  import matmul_feeder_pkg::*;
#(
  parameter int N     = 5,
  parameter int T     = 10,
  parameter int WLEAD = 2
`ifdef MATMUL_FEEDER_TIMEOUT_EN
  ,
  parameter int TMO   = 64
`endif
) (
  input  logic            CLK,
  input  logic            RSTN,
  matmul_feeder_if.slave  s,
  output row_t            weight_o,
  output row_t            in_o,
  input  logic            val_i,
  input  logic            ov_i,
  output logic            busy,
  output logic            done,
  output logic            ov_seen,
  output logic            err
);

  localparam int DEPTH  = N + T;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int RCNT_W = $clog2(T + 1);

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  LAST_W    = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0]  LEAD_END  = PTR_W'(WLEAD - 1);
  localparam logic [PTR_W-1:0]  FIRST_IN  = PTR_W'(N);
  localparam logic [RCNT_W-1:0] LAST_RCNT = RCNT_W'(T - 1);

  state_t             state, state_n;
  logic [PTR_W-1:0]   wptr, wptr_n, rptr, rptr_n, rd_addr;
  logic [RCNT_W-1:0]  rcnt, rcnt_n;
  logic               zflag, zflag_n, seen_zero;
  logic               ready_q, ready_n, busy_n, done_n, ov_n, err_n;
  logic               wr_en, xfer;
  row_t               rd_data, weight_n, in_n;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TMO + 1);
  localparam logic [TCNT_W-1:0] TMO_END = TCNT_W'(TMO - 1);
  logic [TCNT_W-1:0]  tcnt, tcnt_n;
`endif

  assign xfer      = s.s_valid && ready_q;
  assign s.s_ready = ready_q;

  matmul_feeder_buf #(.DEPTH(DEPTH), .AW(PTR_W)) u_buf (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (s.s_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: every signal is given a default before the case so no path leaves
  // a variable unassigned (which would infer a latch).
  always_comb begin
    state_n   = state;
    wptr_n    = wptr;
    rptr_n    = rptr;
    rcnt_n    = rcnt;
    zflag_n   = zflag;
    ov_n      = ov_seen;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    wr_en     = 1'b0;
    seen_zero = zflag || row_is_zero(s.s_data);
`ifdef MATMUL_FEEDER_TIMEOUT_EN
    tcnt_n    = tcnt;
`endif
    unique case (state)
      S_IDLE: if (xfer) begin
        wr_en   = 1'b1;
        wptr_n  = PTR_W'(1);
        zflag_n = row_is_zero(s.s_data);
        ov_n    = 1'b0;
        busy_n  = 1'b1;
        state_n = S_FILL;
      end
      S_FILL: if (xfer) begin
        wr_en = 1'b1;
        if (wptr == LAST_PTR) begin
          wptr_n  = '0;
          zflag_n = 1'b0;
          if (seen_zero) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = S_WLEAD;
            rptr_n  = '0;
          end
        end else begin
          wptr_n  = wptr + 1'b1;
          zflag_n = seen_zero;
        end
      end
      // rptr doubles as the lead-cycle counter while row 0 is held.
      S_WLEAD: begin
        if (rptr == LEAD_END) begin
          state_n = S_WSEND;
          rptr_n  = '0;
        end else begin
          rptr_n  = rptr + 1'b1;
        end
      end
      S_WSEND: begin
        if (rptr == LAST_W) begin
          state_n = S_WTERM;
          rptr_n  = FIRST_IN;
        end else begin
          rptr_n  = rptr + 1'b1;
        end
      end
      S_WTERM: state_n = S_ISEND;
      S_ISEND: begin
        if (rptr == LAST_PTR) begin
          state_n = S_ITERM;
          rptr_n  = '0;
        end else begin
          rptr_n  = rptr + 1'b1;
        end
      end
      S_ITERM: begin
        state_n = S_WAIT;
        rcnt_n  = '0;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
        tcnt_n  = '0;
`endif
      end
      S_WAIT: begin
        ov_n = ov_seen || ov_i;
        if (val_i) rcnt_n = rcnt + 1'b1;
        if (val_i && rcnt == LAST_RCNT) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          rcnt_n  = '0;
        end
`ifdef MATMUL_FEEDER_TIMEOUT_EN
        else if (tcnt == TMO_END) begin
          state_n = S_IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          rcnt_n  = '0;
        end else begin
          tcnt_n  = tcnt + 1'b1;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_IDLE) || (state_n == S_FILL);
  end

  // Outputs are registered from the next state so the data lines line up
  // with the state they belong to.
  always_comb begin
    rd_addr  = (state_n == S_WLEAD) ? '0 : rptr_n;
    weight_n = (state_n == S_WLEAD || state_n == S_WSEND) ? rd_data : '0;
    in_n     = (state_n == S_ISEND) ? rd_data : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      rcnt     <= '0;
      zflag    <= 1'b0;
      ready_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ov_seen  <= 1'b0;
      err      <= 1'b0;
      weight_o <= '0;
      in_o     <= '0;
    end else begin
      state    <= state_n;
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      rcnt     <= rcnt_n;
      zflag    <= zflag_n;
      ready_q  <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
      ov_seen  <= ov_n;
      err      <= err_n;
      weight_o <= weight_n;
      in_o     <= in_n;
    end
  end

`ifdef MATMUL_FEEDER_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) tcnt <= '0;
    else       tcnt <= tcnt_n;
  end
`endif

endmodule

// File: tb/tb_matmul_feeder.sv
// Directed self-checking bench for matmul_feeder (default N=5, T=10, WLEAD=2,
// TMO=64). Inputs are driven and outputs sampled on the falling clock edge.
module tb_matmul_feeder;
  import matmul_feeder_pkg::*;

  localparam int N   = 5;
  localparam int T   = 10;
  localparam int TMO = 64;

  logic CLK = 1'b0;
  logic RSTN;
  logic val_i, ov_i;
  row_t weight_o, in_o;
  logic busy, done, ov_seen, err;

  int   checks   = 0;
  int   failures = 0;
  row_t rows [N+T];

  matmul_feeder_if bus ();

  matmul_feeder dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .s        (bus),
    .weight_o (weight_o),
    .in_o     (in_o),
    .val_i    (val_i),
    .ov_i     (ov_i),
    .busy     (busy),
    .done     (done),
    .ov_seen  (ov_seen),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_row(input row_t d);
    int guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (bus.s_ready !== 1'b1 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      failures++;
      $display("FAIL send_row: s_ready=%b never rose, required 1", bus.s_ready);
    end
    @(negedge CLK);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_job();
    for (int i = 0; i < N + T; i++) send_row(rows[i]);
  endtask

  // Replay window after the last accepted row (c=0 is the first sample).
  // val_i/ov_i are pulsed during ISEND to show they are ignored there.
  task automatic check_replay(input string tag);
    row_t exp_w, exp_i;
    for (int c = 0; c <= 18; c++) begin
      exp_w = '0;
      exp_i = '0;
      if (c <= 1)                 exp_w = rows[0];
      else if (c <= 6)            exp_w = rows[c-2];
      if (c >= 8 && c <= 17)      exp_i = rows[c-3];
      checks++;
      if (weight_o !== exp_w || in_o !== exp_i || busy !== 1'b1 || bus.s_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s c=%0d: weight_o=%h in_o=%h busy=%b s_ready=%b, required weight_o=%h in_o=%h busy=1 s_ready=0",
                 tag, c, weight_o, in_o, busy, bus.s_ready, exp_w, exp_i);
      end
      val_i = (c >= 9 && c <= 11);
      ov_i  = (c >= 9 && c <= 11);
      if (c < 18) @(negedge CLK);
    end
    val_i = 1'b0;
    ov_i  = 1'b0;
  endtask

  task automatic finish_wait(input int beats, input string tag);
    for (int b = 0; b < beats; b++) begin
      val_i = 1'b1;
      @(negedge CLK);
      checks++;
      if (done !== (b == beats - 1)) begin
        failures++;
        $display("FAIL %s beat %0d: done=%b, required %b", tag, b, done, (b == beats - 1));
      end
    end
    val_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s idle: done=%b busy=%b s_ready=%b, required 0 0 1", tag, done, busy, bus.s_ready);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (weight_o !== '0 || in_o !== '0 || busy !== 0 || done !== 0 || ov_seen !== 0 ||
        err !== 0 || bus.s_ready !== 0) begin
      failures++;
      $display("FAIL reset_values: w=%h in=%h busy=%b done=%b ov=%b err=%b rdy=%b, required all 0",
               weight_o, in_o, busy, done, ov_seen, err, bus.s_ready);
    end
    RSTN = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: s_ready=%b, required 0", bus.s_ready);
    end
    @(negedge CLK);
    checks++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_rise: s_ready=%b busy=%b, required 1 0", bus.s_ready, busy);
    end
  endtask

  task automatic test_replay();
    for (int i = 0; i < N + T; i++) rows[i] = 40'h0101010101 * (i + 1);
    send_job();
    check_replay("replay");
  endtask

  task automatic test_done_count();
    int gaps [10] = '{0, 2, 1, 0, 3, 1, 0, 2, 1, 0};
    @(negedge CLK);
    checks++;
    if (done !== 0 || busy !== 1 || ov_seen !== 0 || weight_o !== '0 || in_o !== '0) begin
      failures++;
      $display("FAIL wait_entry: done=%b busy=%b ov_seen=%b w=%h in=%h, required 0 1 0 0 0",
               done, busy, ov_seen, weight_o, in_o);
    end
    for (int b = 0; b < 10; b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL done_gap b=%0d: done=%b busy=%b, required 0 1", b, done, busy);
        end
      end
      val_i = 1'b1;
      ov_i  = (b == 3);
      @(negedge CLK);
      val_i = 1'b0;
      ov_i  = 1'b0;
      checks++;
      if (done !== (b == 9) || busy !== (b != 9) || ov_seen !== (b >= 3)) begin
        failures++;
        $display("FAIL done_beat b=%0d: done=%b busy=%b ov_seen=%b, required %b %b %b",
                 b, done, busy, ov_seen, (b == 9), (b != 9), (b >= 3));
      end
    end
    @(negedge CLK);
    checks++;
    if (done !== 0 || busy !== 0 || ov_seen !== 1 || bus.s_ready !== 1) begin
      failures++;
      $display("FAIL after_done: done=%b busy=%b ov_seen=%b s_ready=%b, required 0 0 1 1",
               done, busy, ov_seen, bus.s_ready);
    end
  endtask

  task automatic test_zero_row();
    for (int i = 0; i < N + T; i++) rows[i] = (i == 7) ? 40'h0 : 40'h10_00_00_00_00 + 40'(i);
    for (int i = 0; i < N + T; i++) begin
      send_row(rows[i]);
      checks++;
      if (i == 0 && ov_seen !== 1'b0) begin
        failures++;
        $display("FAIL ov_clear: ov_seen=%b, required 0", ov_seen);
      end
      if (i < N + T - 1) begin
        if (err !== 0 || busy !== 1 || weight_o !== '0 || in_o !== '0) begin
          failures++;
          $display("FAIL zero_fill row %0d: err=%b busy=%b w=%h in=%h, required 0 1 0 0",
                   i, err, busy, weight_o, in_o);
        end
      end else if (err !== 1 || busy !== 0 || done !== 0 || bus.s_ready !== 1) begin
        failures++;
        $display("FAIL zero_reject: err=%b busy=%b done=%b s_ready=%b, required 1 0 0 1",
                 err, busy, done, bus.s_ready);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (err !== 0 || busy !== 0 || weight_o !== '0 || in_o !== '0) begin
        failures++;
        $display("FAIL zero_quiet c=%0d: err=%b busy=%b w=%h in=%h, required 0 0 0 0",
                 c, err, busy, weight_o, in_o);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    for (int i = 0; i < N + T; i++) rows[i] = {8'(i + 1), 8'hA5, 8'h5A, 8'h3C, 8'(i)};
    send_job();
    repeat (10) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if (in_o !== '0 || weight_o !== '0 || busy !== 0 || bus.s_ready !== 0) begin
      failures++;
      $display("FAIL async_reset: in=%h w=%h busy=%b s_ready=%b, required 0 0 0 0",
               in_o, weight_o, busy, bus.s_ready);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < N + T; i++) rows[i] = ~(40'h0101010101 * (i + 1));
    send_job();
    check_replay("replay_after_reset");
    @(negedge CLK);
    finish_wait(T, "post_reset_wait");
  endtask

  task automatic test_timeout();
    int err_at = -1;
    int done_hits = 0;
    for (int i = 0; i < N + T; i++) rows[i] = 40'h0101010101 * (i + 1);
    send_job();
    check_replay("replay_timeout");
    @(negedge CLK);
    val_i = 1'b1;
    repeat (3) @(negedge CLK);
    val_i = 1'b0;
    for (int c = 22; c <= 19 + TMO + 10; c++) begin
      if (c > 22) @(negedge CLK);
      if (err === 1'b1 && err_at < 0) err_at = c;
      if (done !== 1'b0) done_hits++;
    end
    checks++;
    if (done_hits != 0) begin
      failures++;
      $display("FAIL timeout_done: done seen %0d times, required 0", done_hits);
    end
`ifdef MATMUL_FEEDER_TIMEOUT_EN
    checks++;
    if (err_at != 19 + TMO || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: err at c=%0d busy=%b, required c=%0d busy=0", err_at, busy, 19 + TMO);
    end
`else
    checks++;
    if (err_at != -1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL no_timeout: err at c=%0d busy=%b, required none busy=1", err_at, busy);
    end
    finish_wait(T - 3, "no_timeout_finish");
`endif
  endtask

  initial begin
    RSTN        = 1'b0;
    val_i       = 1'b0;
    ov_i        = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    test_reset();
    test_replay();
    test_done_count();
    test_zero_row();
    test_reset_mid_job();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
